// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame scheduler: fetches GRB words from a frame buffer and serialises them MSB-first to the bit encoder.
// Latency: first bit offered 3 cycles after an accepted start; 3-cycle gap between pixels; latch gap of TPERIOD+TRESET cycles.
// Backpressure: o_bit/o_bit_valid hold until i_bit_ready. Optional WS2812_SCHED_AUTO_REPEAT_EN adds i_repeat to loop frames.
module ws2812_frame_scheduler #(
    parameter int WIDTH_ADDR     = 10,
    parameter int WIDTH_COUNTER  = 16,
    parameter int TPERIOD_CYCLES = 125,
    parameter int TRESET_CYCLES  = 5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [WIDTH_ADDR-1:0] i_num_leds,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [WIDTH_ADDR-1:0] o_rd_addr,
    input  logic [23:0]           i_rd_data,
    output logic                  o_bit_valid,
    output logic                  o_bit,
    input  logic                  i_bit_ready,
`ifdef WS2812_SCHED_AUTO_REPEAT_EN
    input  logic                  i_repeat,
`endif
    output logic                  o_latch
);

    localparam int LAT_TOTAL = TPERIOD_CYCLES + TRESET_CYCLES;
    localparam logic [WIDTH_COUNTER-1:0] LAT_LAST = WIDTH_COUNTER'(LAT_TOTAL - 1);
    localparam logic [WIDTH_COUNTER-1:0] ONE_CNT  = WIDTH_COUNTER'(1);
    localparam logic [WIDTH_ADDR-1:0]    ONE_ADDR = WIDTH_ADDR'(1);

    generate
        if (LAT_TOTAL > (1 << WIDTH_COUNTER) || LAT_TOTAL < 1) begin : g_lat_cnt_chk
            $error("TPERIOD_CYCLES+TRESET_CYCLES does not fit WIDTH_COUNTER");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        SHIFT,
        LATCH
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_ADDR-1:0]    n_leds_q, n_leds_d;
    logic [WIDTH_ADDR-1:0]    led_idx_q, led_idx_d;
    logic [23:0]              shift_q, shift_d;
    logic [4:0]               bit_cnt_q, bit_cnt_d;
    logic [WIDTH_COUNTER-1:0] lat_cnt_q, lat_cnt_d;
    logic                     done_q, done_d;
    logic [WIDTH_ADDR-1:0]    led_idx_inc;

    assign led_idx_inc = led_idx_q + ONE_ADDR;

    always_comb begin
        state_d     = state_q;
        n_leds_d    = n_leds_q;
        led_idx_d   = led_idx_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        done_d      = 1'b0;
        o_rd_en     = 1'b0;
        o_rd_addr   = '0;
        o_bit_valid = 1'b0;
        o_bit       = 1'b0;
        o_latch     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    n_leds_d  = i_num_leds;
                    led_idx_d = '0;
                    if (i_num_leds == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                o_rd_en   = 1'b1;
                o_rd_addr = led_idx_q;
                state_d   = WAIT_DATA;
            end
            WAIT_DATA: begin
                shift_d   = i_rd_data;
                bit_cnt_d = 5'd23;
                state_d   = SHIFT;
            end
            SHIFT: begin
                o_bit_valid = 1'b1;
                o_bit       = shift_q[23];
                if (i_bit_ready) begin
                    shift_d   = {shift_q[22:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                    if (bit_cnt_q == 5'd0) begin
                        // led_idx stops at n_leds-1 on the final pixel so the address never passes the frame
                        if (led_idx_inc == n_leds_q) begin
                            state_d   = LATCH;
                            lat_cnt_d = '0;
                        end else begin
                            led_idx_d = led_idx_inc;
                            state_d   = FETCH;
                        end
                    end
                end
            end
            LATCH: begin
                o_latch = 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    done_d    = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = IDLE;
`ifdef WS2812_SCHED_AUTO_REPEAT_EN
                    if (i_repeat) begin
                        led_idx_d = '0;
                        state_d   = FETCH;
                    end
`endif
                end else begin
                    lat_cnt_d = lat_cnt_q + ONE_CNT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_leds_q  <= '0;
            led_idx_q <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_leds_q  <= n_leds_d;
            led_idx_q <= led_idx_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            done_q    <= done_d;
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench for ws2812_frame_scheduler: frame buffer model, ready driver, event monitor, per-scenario tasks.
module tb_ws2812_frame_scheduler;

    localparam int LATCH_LEN = 125 + 5000;
    localparam int PIX_CYC   = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_num_leds = '0;
    logic        o_busy, o_done, o_rd_en, o_bit_valid, o_bit, o_latch;
    logic [9:0]  o_rd_addr;
    logic [23:0] i_rd_data = '0;
    logic        i_bit_ready = 1'b0;
`ifdef WS2812_SCHED_AUTO_REPEAT_EN
    logic        i_repeat = 1'b0;
`endif

    ws2812_frame_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_num_leds (i_num_leds),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_bit_valid(o_bit_valid),
        .o_bit      (o_bit),
        .i_bit_ready(i_bit_ready),
`ifdef WS2812_SCHED_AUTO_REPEAT_EN
        .i_repeat   (i_repeat),
`endif
        .o_latch    (o_latch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [0:1023];
    int rdy_mode = 0;
    int stall = 0;

    // Frame buffer: data valid only the cycle after a read, garbage otherwise
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
        else         i_rd_data <= 24'($urandom());
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: i_bit_ready = 1'b1;
            1: i_bit_ready = 1'($urandom_range(0, 1));
            default: begin
                if (!o_bit_valid) begin
                    i_bit_ready = 1'b0;
                    stall = 0;
                end else if (stall < 10) begin
                    i_bit_ready = 1'b0;
                    stall++;
                end else begin
                    i_bit_ready = 1'b1;
                    stall = 0;
                end
            end
        endcase
    end

    bit   bits_q[$];
    int   xfer_t[$];
    int   addr_q[$];
    int   latch_cnt, busy_cnt, done_cnt, done_t, stab_err, stall_cyc, latch_bad, done_bad;
    int   cyc = 0;
    bit   prev_stall = 0, prev_bit = 0, allow_busy_done = 0;

    always @(negedge clk) begin
        if (o_bit_valid && i_bit_ready) begin
            bits_q.push_back(o_bit);
            xfer_t.push_back(cyc);
        end
        if (o_rd_en) addr_q.push_back(int'(o_rd_addr));
        if (o_latch) latch_cnt++;
        if (o_latch && o_bit_valid) latch_bad++;
        if (o_busy) busy_cnt++;
        if (o_done) begin
            done_cnt++;
            done_t = cyc;
            if (o_latch || (o_busy && !allow_busy_done)) done_bad++;
        end
        if (prev_stall && (!o_bit_valid || o_bit !== prev_bit)) stab_err++;
        prev_stall = o_bit_valid && !i_bit_ready;
        prev_bit   = o_bit;
        if (o_bit_valid && !i_bit_ready) stall_cyc++;
        cyc++;
    end

    task automatic clear_mon();
        bits_q.delete(); xfer_t.delete(); addr_q.delete();
        latch_cnt = 0; busy_cnt = 0; done_cnt = 0; done_t = -1;
        stab_err = 0; stall_cyc = 0; latch_bad = 0; done_bad = 0;
        prev_stall = 0;
    endtask

    // Reference: frame of n pixels serialised G7..B0, repeating from pixel 0 for looped frames
    function automatic int stream_mismatches(int n);
        int mm = 0;
        for (int k = 0; k < bits_q.size(); k++) begin
            logic [23:0] w = mem[(k / 24) % n];
            if (bits_q[k] !== w[23 - (k % 24)]) mm++;
        end
        return mm;
    endfunction

    function automatic int addr_mismatches(int n);
        int mm = 0;
        for (int k = 0; k < addr_q.size(); k++)
            if (addr_q[k] != (k % n)) mm++;
        return mm;
    endfunction

    task automatic start_frame(input int n, output int s);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_num_leds = 10'(n);
        s = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_num_leds = 10'($urandom());
    endtask

    task automatic run_until_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) mem[i] = 24'($urandom());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_rd_en, o_rd_addr, o_bit_valid, o_bit, o_latch} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {o_busy, o_done, o_rd_en, o_rd_addr, o_bit_valid, o_bit, o_latch});
        end
        rst_n = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy_cnt + done_cnt + addr_q.size() + bits_q.size() + latch_cnt != 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d events want 0", busy_cnt + done_cnt + addr_q.size() + bits_q.size() + latch_cnt);
        end
    endtask

    task automatic test_basic();
        int s;
        rdy_mode = 0;
        mem[0] = 24'hFF0000;
        mem[1] = 24'h00A55A;
        clear_mon();
        start_frame(2, s);
        run_until_done(1, 8000);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
        checks++;
        if (addr_q.size() != 2 || addr_mismatches(2) != 0) begin
            errors++; $display("FAIL basic_addr got %0d reads / %0d bad want 2 / 0", addr_q.size(), addr_mismatches(2));
        end
        checks++;
        if (bits_q.size() != 48 || stream_mismatches(2) != 0) begin
            errors++; $display("FAIL basic_bits got %0d bits / %0d bad want 48 / 0", bits_q.size(), stream_mismatches(2));
        end
        checks++;
        if (latch_cnt != LATCH_LEN) begin errors++; $display("FAIL basic_latch_len got %0d want %0d", latch_cnt, LATCH_LEN); end
        checks++;
        if (done_t != s + PIX_CYC * 2 + LATCH_LEN + 1) begin
            errors++; $display("FAIL basic_done_time got %0d want %0d", done_t - s, PIX_CYC * 2 + LATCH_LEN + 1);
        end
        checks++;
        if (busy_cnt != PIX_CYC * 2 + LATCH_LEN) begin
            errors++; $display("FAIL basic_busy_len got %0d want %0d", busy_cnt, PIX_CYC * 2 + LATCH_LEN);
        end
        checks++;
        if (xfer_t.size() < 25 || xfer_t[24] - xfer_t[23] != 3) begin
            errors++; $display("FAIL basic_pixel_gap got %0d want 3", xfer_t.size() < 25 ? -1 : xfer_t[24] - xfer_t[23]);
        end
        checks++;
        if (done_bad + latch_bad != 0) begin errors++; $display("FAIL basic_done_flags got %0d want 0", done_bad + latch_bad); end
    endtask

    task automatic test_backpressure();
        int s;
        rdy_mode = 2;
        mem[0] = 24'h800001;
        clear_mon();
        start_frame(1, s);
        run_until_done(1, 8000);
        checks++;
        if (bits_q.size() != 24 || stream_mismatches(1) != 0) begin
            errors++; $display("FAIL bp_bits got %0d bits / %0d bad want 24 / 0", bits_q.size(), stream_mismatches(1));
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stab_err); end
        checks++;
        if (stall_cyc != 240) begin errors++; $display("FAIL bp_stall_cycles got %0d want 240", stall_cyc); end
        checks++;
        if (done_cnt != 1 || latch_cnt != LATCH_LEN) begin
            errors++; $display("FAIL bp_end got done %0d latch %0d want 1 %0d", done_cnt, latch_cnt, LATCH_LEN);
        end
        rdy_mode = 0;
    endtask

    task automatic test_zero();
        int s;
        clear_mon();
        start_frame(0, s);
        run_until_done(1, 20);
        checks++;
        if (done_cnt != 1 || done_t != s + 1) begin
            errors++; $display("FAIL zero_done got cnt %0d at +%0d want 1 at +1", done_cnt, done_t - s);
        end
        checks++;
        if (addr_q.size() + busy_cnt + bits_q.size() != 0) begin
            errors++; $display("FAIL zero_quiet got reads %0d busy %0d bits %0d want 0", addr_q.size(), busy_cnt, bits_q.size());
        end
    endtask

    task automatic test_start_ignored();
        int s, s2, k;
        rdy_mode = 0;
        fill_random(3);
        clear_mon();
        start_frame(3, s);
        k = 0;
        while (bits_q.size() < 30 && k < 200) begin @(posedge clk); k++; end
        start_frame(5, s2);
        run_until_done(1, 8000);
        checks++;
        if (addr_q.size() != 3 || addr_mismatches(3) != 0) begin
            errors++; $display("FAIL ignore_addr got %0d reads want 3", addr_q.size());
        end
        checks++;
        if (bits_q.size() != 72 || stream_mismatches(3) != 0) begin
            errors++; $display("FAIL ignore_bits got %0d bits / %0d bad want 72 / 0", bits_q.size(), stream_mismatches(3));
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        int s, k;
        rdy_mode = 0;
        fill_random(5);
        clear_mon();
        start_frame(5, s);
        k = 0;
        while (!(bits_q.size() == 84 && o_bit_valid) && k < 400) begin @(posedge clk); #1; k++; end
        checks++;
        if (bits_q.size() != 84) begin errors++; $display("FAIL abort_reach got %0d bits want 84", bits_q.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_rd_en, o_rd_addr, o_bit_valid, o_bit, o_latch} !== 16'h0) begin
            errors++;
            $display("FAIL abort_outputs got %h want 0", {o_busy, o_done, o_rd_en, o_rd_addr, o_bit_valid, o_bit, o_latch});
        end
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        fill_random(2);
        clear_mon();
        start_frame(2, s);
        run_until_done(1, 8000);
        checks++;
        if (addr_q.size() != 2 || addr_mismatches(2) != 0 || bits_q.size() != 48 || stream_mismatches(2) != 0) begin
            errors++; $display("FAIL abort_restart got reads %0d bits %0d bad %0d want 2 48 0",
                               addr_q.size(), bits_q.size(), stream_mismatches(2));
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL abort_restart_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        int s, n;
        rdy_mode = 1;
        for (int f = 0; f < 2; f++) begin
            n = $urandom_range(1, 6);
            fill_random(n);
            clear_mon();
            start_frame(n, s);
            run_until_done(1, 12000);
            checks++;
            if (addr_q.size() != n || addr_mismatches(n) != 0) begin
                errors++; $display("FAIL rand_addr got %0d reads want %0d", addr_q.size(), n);
            end
            checks++;
            if (bits_q.size() != 24 * n || stream_mismatches(n) != 0) begin
                errors++; $display("FAIL rand_bits got %0d bits / %0d bad want %0d / 0", bits_q.size(), stream_mismatches(n), 24 * n);
            end
            checks++;
            if (done_cnt != 1 || latch_cnt != LATCH_LEN || stab_err + latch_bad + done_bad != 0) begin
                errors++; $display("FAIL rand_end got done %0d latch %0d viol %0d want 1 %0d 0",
                                   done_cnt, latch_cnt, stab_err + latch_bad + done_bad, LATCH_LEN);
            end
        end
        rdy_mode = 0;
    endtask

`ifdef WS2812_SCHED_AUTO_REPEAT_EN
    task automatic test_repeat();
        int s;
        localparam int FRAME = PIX_CYC + LATCH_LEN;
        rdy_mode = 0;
        allow_busy_done = 1;
        fill_random(1);
        clear_mon();
        i_repeat = 1'b1;
        start_frame(1, s);
        run_until_done(2, 12000);
        i_repeat = 1'b0;
        run_until_done(3, 7000);
        checks++;
        if (done_cnt != 3) begin errors++; $display("FAIL rep_done_cnt got %0d want 3", done_cnt); end
        checks++;
        if (addr_q.size() != 3 || addr_mismatches(1) != 0 || bits_q.size() != 72 || stream_mismatches(1) != 0) begin
            errors++; $display("FAIL rep_data got reads %0d bits %0d want 3 72", addr_q.size(), bits_q.size());
        end
        checks++;
        if (busy_cnt != 3 * FRAME || done_t != s + 3 * FRAME + 1) begin
            errors++; $display("FAIL rep_busy got busy %0d end +%0d want %0d +%0d", busy_cnt, done_t - s, 3 * FRAME, 3 * FRAME + 1);
        end
        allow_busy_done = 0;
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_start_ignored();
        test_reset_abort();
        test_random();
`ifdef WS2812_SCHED_AUTO_REPEAT_EN
        test_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
